// File: rtl/id_stage_pipe_pkg.sv
// Shared decode constants for the ID stage: zero-extend opcodes and instruction field offsets.
package id_stage_pipe_pkg;

  localparam logic [3:0] OpZext0 = 4'b0010;
  localparam logic [3:0] OpZext1 = 4'b0011;

  // Fields pack from the top: opcode, rs1, rs2; the immediate sits at bit 0.
  function automatic int unsigned op_lsb(int unsigned ins_w, int unsigned op_w);
    return ins_w - op_w;
  endfunction

  function automatic int unsigned rs1_lsb(int unsigned ins_w, int unsigned op_w,
                                          int unsigned ra_w);
    return ins_w - op_w - ra_w;
  endfunction

  function automatic int unsigned rs2_lsb(int unsigned ins_w, int unsigned op_w,
                                          int unsigned ra_w);
    return ins_w - op_w - 2 * ra_w;
  endfunction

  function automatic int unsigned imm_lsb();
    return 0;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// 2-read / 1-write register file with optional hard-zero register 0 and write-through bypass.
module id_regfile #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned RA_W    = 3,
  parameter bit          R0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [RA_W-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RA_W-1:0]   raddr1,
  input  logic [RA_W-1:0]   raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  localparam int unsigned NumRegs = 2 ** RA_W;

  logic [DATA_W-1:0] mem_q [NumRegs];
  logic              we_eff;

  assign we_eff = we && !(R0_ZERO && (waddr == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NumRegs; i++) mem_q[i] <= '0;
    end else if (we_eff) begin
      mem_q[waddr] <= wdata;
    end
  end

  // A write landing this cycle is visible to the reader so the latch never captures stale data.
  always_comb begin
    rdata1 = mem_q[raddr1];
    rdata2 = mem_q[raddr2];
    if (R0_ZERO && (raddr1 == '0)) rdata1 = '0;
    else if (we_eff && (waddr == raddr1)) rdata1 = wdata;
    if (R0_ZERO && (raddr2 == '0)) rdata2 = '0;
    else if (we_eff && (waddr == raddr2)) rdata2 = wdata;
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Pipelined instruction decode: field decode, register read, immediate extend and ID/EX latch.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int unsigned     DATA_W   = 16,
  parameter int unsigned     INS_W    = 16,
  parameter int unsigned     OP_W     = 4,
  parameter int unsigned     RA_W     = 3,
  parameter int unsigned     IMM_W    = 6,
  parameter logic [OP_W-1:0] ZEXT_OP0 = OpZext0,
  parameter logic [OP_W-1:0] ZEXT_OP1 = OpZext1,
  parameter bit              R0_ZERO  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INS_W-1:0]  npc_in,
  input  logic [INS_W-1:0]  ins_in,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [RA_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_load,
  input  logic [RA_W-1:0]   ex_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INS_W-1:0]  npc_out,
  output logic [INS_W-1:0]  ins_out,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic [DATA_W-1:0] imm_out
);

  localparam int unsigned OpLsb  = op_lsb(INS_W, OP_W);
  localparam int unsigned Rs1Lsb = rs1_lsb(INS_W, OP_W, RA_W);
  localparam int unsigned Rs2Lsb = rs2_lsb(INS_W, OP_W, RA_W);
  localparam int unsigned ImmLsb = imm_lsb();

  logic [OP_W-1:0]   opcode;
  logic [RA_W-1:0]   rs1, rs2;
  logic [IMM_W-1:0]  imm_field;
  logic [DATA_W-1:0] imm_ext, rd1, rd2;
  logic              hazard, latch_free, accept;

  logic              valid_q, valid_d;
  logic [INS_W-1:0]  npc_q, ins_q;
  logic [DATA_W-1:0] rs1_q, rs2_q, imm_q;

  assign opcode    = ins_in[OpLsb +: OP_W];
  assign rs1       = ins_in[Rs1Lsb +: RA_W];
  assign rs2       = ins_in[Rs2Lsb +: RA_W];
  assign imm_field = ins_in[ImmLsb +: IMM_W];

  assign imm_ext = ((opcode == ZEXT_OP0) || (opcode == ZEXT_OP1)) ?
                   {{(DATA_W - IMM_W){1'b0}}, imm_field} :
                   {{(DATA_W - IMM_W){imm_field[IMM_W-1]}}, imm_field};

  id_regfile #(
    .DATA_W (DATA_W),
    .RA_W   (RA_W),
    .R0_ZERO(R0_ZERO)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (wb_en),
    .waddr (wb_addr),
    .wdata (wb_data),
    .raddr1(rs1),
    .raddr2(rs2),
    .rdata1(rd1),
    .rdata2(rd2)
  );

  // A load into the hard-zero register never produces a value worth waiting for.
  assign hazard = ex_load && in_valid && !(R0_ZERO && (ex_rd == '0)) &&
                  ((ex_rd == rs1) || (ex_rd == rs2));

  assign latch_free = !valid_q || out_ready;
  assign in_ready   = latch_free && !hazard && !flush;
  assign accept     = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    if (flush)           valid_d = 1'b0;
    else if (latch_free) valid_d = accept;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      npc_q   <= '0;
      ins_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        npc_q <= npc_in;
        ins_q <= ins_in;
        rs1_q <= rd1;
        rs2_q <= rd2;
        imm_q <= imm_ext;
      end
    end
  end

  assign out_valid = valid_q;
  assign npc_out   = npc_q;
  assign ins_out   = ins_q;
  assign rs1_data  = rs1_q;
  assign rs2_data  = rs2_q;
  assign imm_out   = imm_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed self-checking bench for id_stage_pipe with hand-computed expectations.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] npc_in = '0;
  logic [15:0] ins_in = '0;
  logic        flush = 1'b0;
  logic        wb_en = 1'b0;
  logic [2:0]  wb_addr = '0;
  logic [15:0] wb_data = '0;
  logic        ex_load = 1'b0;
  logic [2:0]  ex_rd = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] npc_out, ins_out, rs1_data, rs2_data, imm_out;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  id_stage_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .npc_in   (npc_in),
    .ins_in   (ins_in),
    .flush    (flush),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .ex_load  (ex_load),
    .ex_rd    (ex_rd),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .npc_out  (npc_out),
    .ins_out  (ins_out),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .imm_out  (imm_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it, away from the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_valid", out_valid, 0);
    check("rst_ins", ins_out, 0);
    check("rst_ready", in_ready, 1);
    step();
    step();
    rst = 1'b1;

    // Immediate extension: zero-extend for op 0010, sign-extend for op 0100
    in_valid = 1; ins_in = 16'h2A3F; npc_in = 16'h0100;
    step();
    check("zext_valid", out_valid, 1);
    check("zext_imm", imm_out, 16'h003F);
    check("zext_npc", npc_out, 16'h0100);
    out_ready = 1; ins_in = 16'h4A3F; npc_in = 16'h0102;
    step();
    check("sext_imm", imm_out, 16'hFFFF);
    check("sext_ins", ins_out, 16'h4A3F);

    // Write-back bypass into rs1=5, then array read-back once the write has committed
    wb_en = 1; wb_addr = 3'd5; wb_data = 16'hBEEF; ins_in = 16'h2A3F;
    step();
    check("bypass_rs1", rs1_data, 16'hBEEF);
    wb_addr = 3'd3; wb_data = 16'h00A5; ins_in = 16'h4000;
    step();
    wb_addr = 3'd0; wb_data = 16'h1234;
    step();
    check("r0_bypass_rs1", rs1_data, 0);
    wb_en = 0; ins_in = 16'h1AC5; npc_in = 16'h0104;
    step();
    check("array_rs1", rs1_data, 16'hBEEF);
    check("array_rs2", rs2_data, 16'h00A5);
    check("sext_pos_imm", imm_out, 16'h0005);
    ins_in = 16'h4000;
    step();
    check("r0_ignored", rs1_data, 0);

    // Load into r0 never stalls
    ex_load = 1; ex_rd = 3'd0; ins_in = 16'h4000;
    #1;
    check("r0_no_hazard", in_ready, 1);

    // Load-use hazard on rs2=2
    ex_rd = 3'd2; ins_in = 16'h1280; npc_in = 16'h0106;
    #1;
    check("hazard_ready", in_ready, 0);
    step();
    check("hazard_bubble", out_valid, 0);
    ex_load = 0;
    #1;
    check("hazard_release", in_ready, 1);
    step();
    check("hazard_accept_v", out_valid, 1);
    check("hazard_accept_i", ins_out, 16'h1280);

    // Back-pressure: latch holds for 3 cycles
    out_ready = 0; ins_in = 16'h2A3F; npc_in = 16'h0108;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_ready", in_ready, 0);
      step();
      check("stall_valid", out_valid, 1);
      check("stall_ins", ins_out, 16'h1280);
      check("stall_npc", npc_out, 16'h0106);
      check("stall_imm", imm_out, 16'h0000);
    end
    out_ready = 1;
    step();
    check("replace_valid", out_valid, 1);
    check("replace_ins", ins_out, 16'h2A3F);
    check("replace_npc", npc_out, 16'h0108);

    // Flush with a full latch; a concurrent register write still commits
    out_ready = 0; flush = 1; ins_in = 16'h4A3F; npc_in = 16'h010A;
    wb_en = 1; wb_addr = 3'd6; wb_data = 16'h7777;
    #1;
    check("flush_ready", in_ready, 0);
    step();
    check("flush_valid", out_valid, 0);
    check("flush_not_taken", ins_out, 16'h2A3F);
    flush = 0; wb_en = 0; ins_in = 16'h1C00; npc_in = 16'h010C;
    step();
    check("flush_wb_commit", rs1_data, 16'h7777);
    check("post_flush_valid", out_valid, 1);

    // Asynchronous reset mid-cycle, no edge needed
    #2;
    rst = 0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_rs1", rs1_data, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
